// File: rtl/ysyx_22050612_ifu.sv
// Non-speculative instruction fetch stage: one aligned doubleword fetch per instruction,
// word select by pc[2], valid/ready handoff to decode, then wait for execute to return dnpc.
module ysyx_22050612_ifu #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter logic [15:0] TIMEOUT  = 16'd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        exu_done,
  input  logic [63:0] exu_dnpc,
  output logic        fetch_err,
  output logic [63:0] fetch_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_VALID = 3'd3;
  localparam logic [2:0] S_EXEC  = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  logic [2:0]  state;
  logic [63:0] pc;
  logic [15:0] wait_cnt;

  // A misaligned pc never raises a request; the REQ cycle is spent moving to HALT.
  assign mem_req_valid = (state == S_REQ) && (pc[1:0] == 2'b00);
  assign mem_req_addr  = {pc[63:3], 3'b000};
  assign inst_valid    = (state == S_VALID);

  // The watchdog trips in the cycle wait_cnt equals TIMEOUT; a response in that
  // same cycle takes priority over the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      inst        <= 32'd0;
      inst_pc     <= RESET_PC;
      fetch_err   <= 1'b0;
      fetch_count <= 64'd0;
      wait_cnt    <= 16'd0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (pc[1:0] != 2'b00) begin
            fetch_err <= 1'b1;
            state     <= S_HALT;
          end else if (mem_req_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            inst     <= pc[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];
            inst_pc  <= pc;
            wait_cnt <= 16'd0;
            state    <= S_VALID;
          end else if ((TIMEOUT != 16'd0) && (wait_cnt == TIMEOUT)) begin
            fetch_err <= 1'b1;
            state     <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_VALID: begin
          if (inst_ready) begin
            fetch_count <= fetch_count + 64'd1;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (exu_done) begin
            pc    <= exu_dnpc;
            state <= S_REQ;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Self-checking bench for ysyx_22050612_ifu: directed scenarios plus a randomized fetch stream
// checked against a doubleword memory model and an instruction-count model.
module tb_ysyx_22050612_ifu;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam int          TMO      = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        exu_done;
  logic [63:0] exu_dnpc;
  logic        fetch_err;
  logic [63:0] fetch_count;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_count;
  logic [63:0] mem_model [logic [63:0]];

  ysyx_22050612_ifu #(.RESET_PC(RESET_PC), .TIMEOUT(16'(TMO))) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .exu_done(exu_done), .exu_dnpc(exu_dnpc),
    .fetch_err(fetch_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Memory model: lazily filled doublewords keyed by aligned address.
  function logic [63:0] model_dw(input logic [63:0] a);
    logic [63:0] key;
    key = a & ~64'h7;
    if (!mem_model.exists(key)) mem_model[key] = {$urandom, $urandom};
    return mem_model[key];
  endfunction

  function logic [31:0] model_inst(input logic [63:0] p);
    logic [63:0] dw;
    dw = model_dw(p);
    return 32'(dw >> (((p % 64'd8) / 64'd4) * 64'd32));
  endfunction

  task idle_inputs;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    inst_ready = 0; exu_done = 0; exu_dnpc = 0;
  endtask

  task pulse_reset;
    rst_n = 0; idle_inputs();
    @(negedge clk);
    rst_n = 1; exp_count = 0;
  endtask

  task test_reset;
    rst_n = 0; idle_inputs();
    repeat (2) @(negedge clk);
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid got=%b want=0", mem_req_valid); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_inst_valid got=%b want=0", inst_valid); end
    checks++; if (inst !== 32'd0) begin errors++; $display("[TB] FAIL reset_inst got=%h want=0", inst); end
    checks++; if (inst_pc !== RESET_PC) begin errors++; $display("[TB] FAIL reset_inst_pc got=%h want=%h", inst_pc, RESET_PC); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_fetch_err got=%b want=0", fetch_err); end
    checks++; if (fetch_count !== 64'd0) begin errors++; $display("[TB] FAIL reset_count got=%0d want=0", fetch_count); end
    checks++; if (mem_req_addr !== RESET_PC) begin errors++; $display("[TB] FAIL reset_addr got=%h want=%h", mem_req_addr, RESET_PC); end
    rst_n = 1; exp_count = 0;
  endtask

  task test_first_fetch;
    mem_model[RESET_PC] = 64'h00100073_00000413;
    mem_req_ready = 1;
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL t1_req_valid got=%b want=1", mem_req_valid); end
    checks++; if (mem_req_addr !== 64'h8000_0000) begin errors++; $display("[TB] FAIL t1_addr got=%h want=80000000", mem_req_addr); end
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL t1_req_retired got=%b want=0", mem_req_valid); end
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 64'h00100073_00000413;
    @(negedge clk);
    mem_resp_valid = 0;
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL t1_inst_valid_cycle2 got=%b want=1", inst_valid); end
    checks++; if (inst !== 32'h0000_0413) begin errors++; $display("[TB] FAIL t1_inst got=%h want=00000413", inst); end
    checks++; if (inst_pc !== 64'h8000_0000) begin errors++; $display("[TB] FAIL t1_inst_pc got=%h want=80000000", inst_pc); end
    checks++; if (fetch_count !== exp_count) begin errors++; $display("[TB] FAIL t1_count_before got=%0d want=%0d", fetch_count, exp_count); end
    inst_ready = 1;
    @(negedge clk);
    inst_ready = 0; exp_count++;
    checks++; if (fetch_count !== exp_count) begin errors++; $display("[TB] FAIL t1_count got=%0d want=%0d", fetch_count, exp_count); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL t1_inst_valid_drop got=%b want=0", inst_valid); end
  endtask

  task test_second_word;
    exu_done = 1; exu_dnpc = 64'h8000_0004;
    @(negedge clk);
    exu_done = 0; exu_dnpc = 0;
    checks++; if (mem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL t2_req_after_done got=%b want=1", mem_req_valid); end
    checks++; if (mem_req_addr !== 64'h8000_0000) begin errors++; $display("[TB] FAIL t2_addr got=%h want=80000000", mem_req_addr); end
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = model_dw(64'h8000_0004);
    @(negedge clk);
    mem_resp_valid = 0;
    checks++; if (inst !== 32'h0010_0073) begin errors++; $display("[TB] FAIL t2_inst got=%h want=00100073", inst); end
    checks++; if (inst_pc !== 64'h8000_0004) begin errors++; $display("[TB] FAIL t2_inst_pc got=%h want=80000004", inst_pc); end
    inst_ready = 1;
    @(negedge clk);
    inst_ready = 0; exp_count++;
    checks++; if (fetch_count !== exp_count) begin errors++; $display("[TB] FAIL t2_count got=%0d want=%0d", fetch_count, exp_count); end
  endtask

  task test_backpressure;
    logic [31:0] exp_inst;
    exu_done = 1; exu_dnpc = 64'h8000_0010;
    @(negedge clk);
    exu_done = 0;
    for (int i = 0; i <= 5; i++) begin
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0010) begin errors++; $display("[TB] FAIL t3_req_stable valid=%b addr=%h want 1/80000010", mem_req_valid, mem_req_addr); end
      if (i < 5) @(negedge clk);
    end
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = model_dw(64'h8000_0010);
    @(negedge clk);
    mem_resp_valid = 0;
    exp_inst = model_inst(64'h8000_0010);
    for (int i = 0; i < 3; i++) begin
      checks++; if (inst_valid !== 1'b1 || inst !== exp_inst || inst_pc !== 64'h8000_0010) begin errors++; $display("[TB] FAIL t3_inst_stable valid=%b inst=%h pc=%h want 1/%h/80000010", inst_valid, inst, inst_pc, exp_inst); end
      checks++; if (fetch_count !== exp_count) begin errors++; $display("[TB] FAIL t3_no_extra_count got=%0d want=%0d", fetch_count, exp_count); end
      @(negedge clk);
    end
    inst_ready = 1;
    @(negedge clk);
    inst_ready = 0; exp_count++;
    checks++; if (fetch_count !== exp_count) begin errors++; $display("[TB] FAIL t3_count got=%0d want=%0d", fetch_count, exp_count); end
  endtask

  task test_random_stream;
    logic [63:0] npc;
    logic [31:0] exp_inst;
    int d;
    for (int t = 0; t < 30; t++) begin
      npc = RESET_PC + 64'($urandom_range(0, 1023)) * 64'd4;
      exp_inst = model_inst(npc);
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        mem_resp_valid = 1; mem_resp_data = {$urandom, $urandom};
        @(negedge clk);
      end
      mem_resp_valid = 0;
      exu_done = 1; exu_dnpc = npc;
      @(negedge clk);
      d = $urandom_range(0, 3);
      for (int i = 0; i <= d; i++) begin
        checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== (npc & ~64'h7)) begin errors++; $display("[TB] FAIL rnd_req valid=%b addr=%h want 1/%h", mem_req_valid, mem_req_addr, npc & ~64'h7); end
        if (i < d) begin
          exu_done = 1; exu_dnpc = {$urandom, $urandom};
          @(negedge clk);
        end
      end
      exu_done = 0; mem_req_ready = 1;
      @(negedge clk);
      mem_req_ready = 0;
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        checks++; if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rnd_wait_idle req=%b inst_valid=%b want 0/0", mem_req_valid, inst_valid); end
        exu_done = 1; exu_dnpc = {$urandom, $urandom};
        @(negedge clk);
      end
      exu_done = 0; mem_resp_valid = 1; mem_resp_data = model_dw(npc);
      @(negedge clk);
      d = $urandom_range(0, 3);
      for (int i = 0; i <= d; i++) begin
        checks++; if (inst_valid !== 1'b1 || inst !== exp_inst || inst_pc !== npc) begin errors++; $display("[TB] FAIL rnd_inst valid=%b inst=%h pc=%h want 1/%h/%h", inst_valid, inst, inst_pc, exp_inst, npc); end
        if (i < d) begin
          mem_resp_valid = 1; mem_resp_data = {$urandom, $urandom};
          @(negedge clk);
        end
      end
      mem_resp_valid = 0; inst_ready = 1;
      @(negedge clk);
      inst_ready = 0; exp_count++;
      checks++; if (fetch_count !== exp_count || inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rnd_count got=%0d valid=%b want %0d/0", fetch_count, inst_valid, exp_count); end
    end
  endtask

  task test_timeout;
    pulse_reset();
    mem_req_ready = 1;
    @(negedge clk);
    @(negedge clk);
    mem_req_ready = 0;
    for (int k = 0; k <= TMO; k++) begin
      checks++; if (fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL t5_err_early cycle=%0d got=%b want=0", k, fetch_err); end
      @(negedge clk);
    end
    checks++; if (fetch_err !== 1'b1) begin errors++; $display("[TB] FAIL t5_err_set got=%b want=1", fetch_err); end
    checks++; if (mem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL t5_halt_idle req=%b inst_valid=%b want 0/0", mem_req_valid, inst_valid); end
    exu_done = 1; exu_dnpc = RESET_PC; mem_resp_valid = 1; mem_req_ready = 1; inst_ready = 1;
    repeat (3) @(negedge clk);
    checks++; if (fetch_err !== 1'b1 || mem_req_valid !== 1'b0 || inst_valid !== 1'b0 || fetch_count !== 64'd0) begin errors++; $display("[TB] FAIL t5_halt_sticky err=%b req=%b iv=%b cnt=%0d want 1/0/0/0", fetch_err, mem_req_valid, inst_valid, fetch_count); end
    idle_inputs();
  endtask

  task test_late_response;
    pulse_reset();
    mem_req_ready = 1;
    @(negedge clk);
    @(negedge clk);
    mem_req_ready = 0;
    repeat (TMO) @(negedge clk);
    mem_resp_valid = 1; mem_resp_data = model_dw(RESET_PC);
    @(negedge clk);
    mem_resp_valid = 0;
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("[TB] FAIL t5b_resp_wins got=%b want=0", fetch_err); end
    checks++; if (inst_valid !== 1'b1 || inst !== model_inst(RESET_PC)) begin errors++; $display("[TB] FAIL t5b_inst valid=%b inst=%h want 1/%h", inst_valid, inst, model_inst(RESET_PC)); end
    inst_ready = 1;
    @(negedge clk);
    inst_ready = 0; exp_count++;
    checks++; if (fetch_count !== exp_count) begin errors++; $display("[TB] FAIL t5b_count got=%0d want=%0d", fetch_count, exp_count); end
  endtask

  task test_misaligned;
    exu_done = 1; exu_dnpc = 64'h8000_0006; mem_req_ready = 1;
    @(negedge clk);
    exu_done = 0;
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL t4_no_request got=%b want=0", mem_req_valid); end
    @(negedge clk);
    checks++; if (fetch_err !== 1'b1) begin errors++; $display("[TB] FAIL t4_err got=%b want=1", fetch_err); end
    mem_resp_valid = 1; inst_ready = 1;
    repeat (3) @(negedge clk);
    checks++; if (fetch_err !== 1'b1 || mem_req_valid !== 1'b0 || inst_valid !== 1'b0 || fetch_count !== exp_count) begin errors++; $display("[TB] FAIL t4_halt err=%b req=%b iv=%b cnt=%0d want 1/0/0/%0d", fetch_err, mem_req_valid, inst_valid, fetch_count, exp_count); end
    idle_inputs();
  endtask

  task test_reset_in_wait;
    pulse_reset();
    mem_req_ready = 1;
    @(negedge clk);
    @(negedge clk);
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = model_dw(RESET_PC);
    @(negedge clk);
    mem_resp_valid = 0; inst_ready = 1;
    @(negedge clk);
    inst_ready = 0; exu_done = 1; exu_dnpc = 64'h8000_0100;
    @(negedge clk);
    exu_done = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++; if (fetch_count !== 64'd0 || inst_pc !== RESET_PC || inst !== 32'd0) begin errors++; $display("[TB] FAIL t6_async_reset cnt=%0d pc=%h inst=%h want 0/%h/0", fetch_count, inst_pc, inst, RESET_PC); end
    checks++; if (mem_req_addr !== RESET_PC || mem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL t6_reset_req addr=%h valid=%b want %h/0", mem_req_addr, mem_req_valid, RESET_PC); end
    @(negedge clk);
    rst_n = 1; exp_count = 0;
    mem_resp_valid = 1; mem_resp_data = {$urandom, $urandom};
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== RESET_PC) begin errors++; $display("[TB] FAIL t6_refetch valid=%b addr=%h want 1/%h", mem_req_valid, mem_req_addr, RESET_PC); end
    @(negedge clk);
    checks++; if (inst_valid !== 1'b0 || mem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL t6_stale_resp iv=%b req=%b want 0/1", inst_valid, mem_req_valid); end
    mem_resp_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = model_dw(RESET_PC);
    @(negedge clk);
    mem_resp_valid = 0;
    checks++; if (inst !== model_inst(RESET_PC) || inst_pc !== RESET_PC || fetch_count !== 64'd0) begin errors++; $display("[TB] FAIL t6_fetch inst=%h pc=%h cnt=%0d want %h/%h/0", inst, inst_pc, fetch_count, model_inst(RESET_PC), RESET_PC); end
    inst_ready = 1;
    @(negedge clk);
    inst_ready = 0; exp_count++;
    checks++; if (fetch_count !== exp_count) begin errors++; $display("[TB] FAIL t6_count got=%0d want=%0d", fetch_count, exp_count); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_second_word();
    test_backpressure();
    test_random_stream();
    test_timeout();
    test_late_response();
    test_misaligned();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
